decode_buffer: RTL
==================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 Parameters (name, default, meaning):
- XLEN, 64, PC width
- ILEN, 64, instruction word width
- DEPTH, 4, entry count; power of two, at least 2
- BYPASS, 0, 1 lets an empty buffer pass its input to the output in the same cycle
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, all state on rising edge
- rst_n, in, 1, reset, asynchronous, active-low
- flush_in, in, 1, synchronous discard of all entries
- in_valid, in, 1, upstream entry offered
- in_ready, out, 1, buffer accepts the offered entry
- pc_in, in, XLEN, PC of the offered entry
- instr_in, in, ILEN, instruction of the offered entry
- branch_predicted_taken_in, in, 1, prediction bit of the offered entry
- out_valid, out, 1, head entry presented
- out_ready, in, 1, downstream consumes the head entry
- pc_out, out, XLEN, PC of the head entry
- instr_out, out, ILEN, instruction of the head entry
- branch_predicted_taken_out, out, 1, prediction bit of the head entry
- count_out, out, $clog2(DEPTH+1), occupancy
- full_out, out, 1, count_out equals DEPTH
- empty_out, out, 1, count_out equals 0

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries {pc, instr, pred}, with a write pointer, a read pointer and an occupancy counter.
REQ-004 Push SHALL occur on a rising edge when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
REQ-005 in_ready SHALL equal (count_out < DEPTH) and not flush_in; it is combinational and independent of in_valid.
REQ-006 With BYPASS=0, out_valid SHALL equal (count_out != 0) and not flush_in, and the data outputs SHALL show the entry at the read pointer.
REQ-007 With BYPASS=1 and count_out=0:
- out_valid and the data outputs SHALL follow in_valid and the inputs combinationally.
- If out_ready is also high, the entry SHALL NOT be written and the count SHALL stay 0.
REQ-008 Latency SHALL be 1 cycle from push to out_valid with BYPASS=0, and 0 cycles with BYPASS=1 when empty.
REQ-009 Simultaneous push and pop with 0 < count < DEPTH SHALL leave the count unchanged and advance both pointers.
REQ-010 When full, in_ready SHALL be low even if out_ready is high; a full buffer has no same-cycle pass-through.
REQ-011 Pointers SHALL wrap modulo DEPTH; the count SHALL never exceed DEPTH or go below 0.
REQ-012 flush_in high on an edge SHALL zero both pointers and the count, and SHALL block push and pop in that cycle; flush takes priority over all transfers.
REQ-013 Data outputs SHALL be don't-care while out_valid is low; the bench SHALL NOT check them then.
REQ-014 Entry order SHALL be strictly FIFO; entries SHALL carry pc, instr and the prediction bit together, bit-exact.

Reset
REQ-015 rst_n low SHALL immediately, without a clock, force pointers and count to 0, so that:
- out_valid=0, full_out=0, empty_out=1
- in_ready=1, once rst_n has been released
REQ-016 Storage contents SHALL NOT require reset.
REQ-017 Reset asserted mid-transfer SHALL discard all entries; after release the buffer behaves as empty.
REQ-018 rst_n deassertion SHALL be synchronised externally; the block samples no input until the first rising edge after release.

Verification
REQ-019 Fill then drain (DEPTH=4, BYPASS=0): push pc 0x100/0x104/0x108/0x10C with out_ready=0 -> count 4, full_out=1, in_ready=0; then out_ready=1 -> pc_out 0x100, 0x104, 0x108, 0x10C on consecutive cycles, then empty_out=1.
REQ-020 Wrap-around: 10 push/pop pairs with count held at 2 -> order preserved across pointer wrap, count stays 2.
REQ-021 Flush: count 3, flush_in with in_valid=1 and out_ready=1 -> next cycle count 0, nothing popped, offered entry not stored.
REQ-022 Bypass (BYPASS=1): empty, in_valid=1, out_ready=1, instr 0xDEADBEEF -> same cycle out_valid=1, instr_out 0xDEADBEEF, count stays 0.
REQ-023 Asynchronous reset: count 2, rst_n low between clock edges -> out_valid=0 and count_out=0 before the next edge.
REQ-024 Full with out_ready high: count 4, in_valid=1, out_ready=1 -> one pop, no push, count 3 next cycle.

Source files
------------

// File: rtl/decode_buffer.sv
// Decode-stage instruction buffer: circular FIFO of {pc, instr, pred} entries with
// valid/ready on both sides, synchronous flush and optional empty pass-through.
module decode_buffer #(
    parameter int XLEN   = 64,
    parameter int ILEN   = 64,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [ILEN-1:0]            instr_in,
    input  logic                       branch_predicted_taken_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            pc_out,
    output logic [ILEN-1:0]            instr_out,
    output logic                       branch_predicted_taken_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       full_out,
    output logic                       empty_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [ILEN-1:0] r_instr_mem [DEPTH];
    logic            r_pred_mem  [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_bypass = (BYPASS != 0) && w_empty;

    // Handshake: a transfer happens on a rising edge when valid and ready are both high;
    // ready never depends on valid, and flush_in forces both sides idle.
    assign in_ready  = !w_full && !flush_in;
    assign out_valid = (w_bypass ? in_valid : !w_empty) && !flush_in;

    assign pc_out                     = w_bypass ? pc_in : r_pc_mem[r_rd_ptr];
    assign instr_out                  = w_bypass ? instr_in : r_instr_mem[r_rd_ptr];
    assign branch_predicted_taken_out = w_bypass ? branch_predicted_taken_in : r_pred_mem[r_rd_ptr];

    // A passed-through entry is consumed downstream, so it neither enters nor leaves storage.
    assign w_push = in_valid && in_ready && !(w_bypass && out_ready);
    assign w_pop  = out_valid && out_ready && !w_bypass;

    assign count_out = r_count;
    assign full_out  = w_full;
    assign empty_out = w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is data-only and needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= pc_in;
            r_instr_mem[r_wr_ptr] <= instr_in;
            r_pred_mem[r_wr_ptr]  <= branch_predicted_taken_in;
        end
    end
endmodule
